// File: rtl/adsr_env_ctrl_pkg.sv
// Shared encodings and constants for the ADSR envelope sequencer.
// State codes are fixed 3-bit values so downstream logic can decode them directly.
package adsr_env_ctrl_pkg;

   typedef logic [2:0] env_state_t;

   localparam env_state_t ENV_IDLE    = 3'd0;
   localparam env_state_t ENV_ATTACK  = 3'd1;
   localparam env_state_t ENV_DECAY   = 3'd2;
   localparam env_state_t ENV_SUSTAIN = 3'd3;
   localparam env_state_t ENV_RELEASE = 3'd4;

   localparam int ENV_GAIN_MAX     = 64;
   localparam int ENV_SUSTAIN_GAIN = 32;
   localparam int ENV_NUM_STEPS    = 10;

   // Phase that follows the last step of a timed phase.
   function automatic env_state_t next_phase(input env_state_t s);
      case (s)
         ENV_ATTACK:  next_phase = ENV_DECAY;
         ENV_DECAY:   next_phase = ENV_SUSTAIN;
         default:     next_phase = ENV_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/adsr_gain_lut.sv
// Combinational (state, step) -> 7-bit linear gain in 1/64 units.
module adsr_gain_lut
   import adsr_env_ctrl_pkg::*;
(
   input  logic [2:0] state,
   input  logic [3:0] step,
   output logic [6:0] gain
);

   logic [6:0] rise;
   logic [6:0] half;

   // rise = floor((k+1)*64/10), half = floor((k+1)*32/10); out-of-range steps saturate.
   always_comb begin
      case (step)
         4'd0:    begin rise = 7'd6;  half = 7'd3;  end
         4'd1:    begin rise = 7'd12; half = 7'd6;  end
         4'd2:    begin rise = 7'd19; half = 7'd9;  end
         4'd3:    begin rise = 7'd25; half = 7'd12; end
         4'd4:    begin rise = 7'd32; half = 7'd16; end
         4'd5:    begin rise = 7'd38; half = 7'd19; end
         4'd6:    begin rise = 7'd44; half = 7'd22; end
         4'd7:    begin rise = 7'd51; half = 7'd25; end
         4'd8:    begin rise = 7'd57; half = 7'd28; end
         default: begin rise = 7'd64; half = 7'd32; end
      endcase
   end

   always_comb begin
      case (state)
         ENV_ATTACK:  gain = rise;
         ENV_DECAY:   gain = 7'(ENV_GAIN_MAX) - half;
         ENV_SUSTAIN: gain = 7'(ENV_SUSTAIN_GAIN);
         ENV_RELEASE: gain = 7'(ENV_SUSTAIN_GAIN) - half;
         default:     gain = 7'd0;
      endcase
   end

endmodule

// File: rtl/adsr_env_ctrl.sv
// Gate-driven ADSR sequencer for one voice, advanced by the codec sample tick.
// All outputs are registered and refresh one clk after each in_ready.
module adsr_env_ctrl
   import adsr_env_ctrl_pkg::*;
#(
   parameter int STEP_SAMPLES = 480,
   parameter int NUM_STEPS    = 10,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_ready,
   input  logic       gate,
   output logic [2:0] env_state,
   output logic [3:0] env_step,
   output logic [6:0] env_gain,
   output logic       env_valid,
   output logic       env_active
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_SAMPLES - 1);
   localparam logic [3:0]       STEP_LAST = 4'(NUM_STEPS - 1);

   logic             gate_q, retrig_flag, rise, retrig, advance;
   env_state_t       st, st_nx;
   logic [3:0]       step, step_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [6:0]       gain_nx;

   assign rise   = gate & ~gate_q;
   // A rise between ticks is latched so short gate pulses still retrigger.
   assign retrig = retrig_flag | rise;

   always_comb begin
      st_nx   = st;
      step_nx = step;
      cnt_nx  = cnt;
      advance = 1'b0;
      if (retrig || (st == ENV_IDLE && gate)) begin
         st_nx   = ENV_ATTACK;
         step_nx = '0;
         cnt_nx  = '0;
      end else begin
         case (st)
            ENV_IDLE: begin end
            ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN: begin
               if (!gate) begin
                  st_nx   = ENV_RELEASE;
                  step_nx = '0;
                  cnt_nx  = '0;
               end else begin
                  advance = (st != ENV_SUSTAIN);
               end
            end
            ENV_RELEASE: advance = 1'b1;
            default: begin
               st_nx   = ENV_IDLE;
               step_nx = '0;
               cnt_nx  = '0;
            end
         endcase
         if (advance) begin
            if (cnt == CNT_LAST) begin
               cnt_nx = '0;
               if (step == STEP_LAST) begin
                  st_nx   = next_phase(st);
                  step_nx = '0;
               end else begin
                  step_nx = step + 4'd1;
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
      end
   end

   // Gain is looked up from the next state so it registers alongside it.
   adsr_gain_lut u_gain_lut (
      .state (st_nx),
      .step  (step_nx),
      .gain  (gain_nx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         gate_q      <= 1'b0;
         retrig_flag <= 1'b0;
         st          <= ENV_IDLE;
         step        <= '0;
         cnt         <= '0;
         env_gain    <= '0;
         env_valid   <= 1'b0;
         env_active  <= 1'b0;
      end else begin
         gate_q    <= gate;
         env_valid <= in_ready;
         if (in_ready) begin
            retrig_flag <= 1'b0;
            st          <= st_nx;
            step        <= step_nx;
            cnt         <= cnt_nx;
            env_gain    <= gain_nx;
            env_active  <= (st_nx != ENV_IDLE);
         end else if (rise) begin
            retrig_flag <= 1'b1;
         end
      end
   end

   assign env_state = st;
   assign env_step  = step;

endmodule
